// File: rtl/bram_snapshot_pkg.sv
// bram_snapshot_pkg: shared state encoding for the BRAM snapshot writer
package bram_snapshot_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/bram_snapshot_writer_decim.sv
// snapshot_decim: keeps the first valid sample after trigger, then every (decim+1)-th valid sample
module snapshot_decim #(
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   active,
  input  logic                   valid,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic                   keep
);
  logic [DECIM_WIDTH-1:0] d, cnt, cur_d, cur_cnt;
  assign cur_d   = start ? decim : d;
  assign cur_cnt = start ? '0 : cnt;
  assign keep    = cur_cnt == '0;
  // Hold the factor from the trigger cycle and count valid samples modulo decim+1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d   <= '0;
      cnt <= '0;
    end else begin
      if (start) d <= decim;
      if ((start || active) && valid) cnt <= (cur_cnt == cur_d) ? '0 : cur_cnt + 1'b1;
      else if (start) cnt <= '0;
    end
endmodule

// File: rtl/bram_snapshot_writer.sv
// bram_snapshot_writer: arm/trigger burst capture into a BRAM port; BRAM_SNAPSHOT_DECIM_EN adds decimation
module bram_snapshot_writer
  import bram_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 10,
  parameter int CAPTURE_LEN = 2 ** ADDR_WIDTH,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   fpga_clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   din_valid,
  input  logic                   trigger,
  input  logic                   arm,
  input  logic                   abort,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [DATA_WIDTH-1:0]  bram_din,
  output logic                   bram_we,
  output logic                   armed,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    wr_count
);
  localparam logic [ADDR_WIDTH:0] LEN = (ADDR_WIDTH + 1)'(CAPTURE_LEN);
  state_t state, nxt;
  logic trig, in_cap, arm_ok, keep, acc, last;
  logic [ADDR_WIDTH:0] base;
  assign trig   = state == ARMED && trigger && !abort;
  assign in_cap = state == CAPTURE && !abort;
  assign arm_ok = arm && !abort && (state == IDLE || state == DONE);
  assign acc    = (trig || in_cap) && din_valid && keep;
  assign base   = trig ? '0 : wr_count;
  assign last   = acc && (base + 1'b1 == LEN);
`ifdef BRAM_SNAPSHOT_DECIM_EN
  snapshot_decim #(.DECIM_WIDTH(DECIM_WIDTH)) u_decim (
    .clk   (fpga_clk),
    .rst_n (rst_n),
    .start (trig),
    .active(in_cap),
    .valid (din_valid),
    .decim (decim),
    .keep  (keep)
  );
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign keep = 1'b1;
`endif
  // State register
  always_ff @(posedge fpga_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // Next state: abort beats arm; arm only from IDLE/DONE; final write ends the burst
  always_comb
    nxt = abort ? IDLE : arm_ok ? ARMED : last ? DONE : trig ? CAPTURE : state;
  // Status flags decoded from the registered state
  always_comb begin
    armed = state == ARMED;
    busy  = state == CAPTURE;
    done  = state == DONE;
  end
  // Registered BRAM write port and sample counter
  always_ff @(posedge fpga_clk or negedge rst_n)
    if (!rst_n) begin
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      wr_count  <= '0;
    end else begin
      bram_we <= acc;
      if (acc) begin
        bram_addr <= base[ADDR_WIDTH-1:0];
        bram_din  <= din;
      end
      wr_count <= (abort || arm_ok) ? '0 : acc ? base + 1'b1 : wr_count;
    end
endmodule

// File: tb/tb_bram_snapshot_writer.sv
// tb_bram_snapshot_writer: directed + random stimulus against a sample-level reference model
module tb_bram_snapshot_writer;
  localparam int DW = 16, AW = 4, LEN = 16, DCW = 8;
`ifdef BRAM_SNAPSHOT_DECIM_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  logic fpga_clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic din_valid = 1'b0, trigger = 1'b0, arm = 1'b0, abort = 1'b0;
  logic [DCW-1:0] decim = '0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic bram_we, armed, busy, done;
  logic [AW:0] wr_count;
  int checks = 0, failures = 0;
  int ph = 0, cnt = 0, nv = 0, dl = 0;
  bit e_we = 0;
  int e_addr = 0, e_din = 0;

  bram_snapshot_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPTURE_LEN(LEN), .DECIM_WIDTH(DCW)) dut (
    .fpga_clk (fpga_clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_valid(din_valid),
    .trigger  (trigger),
    .arm      (arm),
    .abort    (abort),
    .decim    (decim),
    .bram_addr(bram_addr),
    .bram_din (bram_din),
    .bram_we  (bram_we),
    .armed    (armed),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero();
    check("rst_we", 32'(bram_we), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_din", 32'(bram_din), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(wr_count), 0);
  endtask

  task automatic mreset();
    ph = 0; cnt = 0; nv = 0; dl = 0; e_we = 0;
  endtask

  // one clock cycle: drive inputs, advance the model by the spec rules, compare after the edge
  task automatic cyc(input bit a, input bit ab, input bit tr, input bit v, input int d, input int dc);
    @(negedge fpga_clk);
    arm = a; abort = ab; trigger = tr; din_valid = v; din = DW'(d); decim = DCW'(dc);
    e_we = 0;
    if (ab) begin ph = 0; cnt = 0; end
    else if (a && (ph == 0 || ph == 3)) begin ph = 1; cnt = 0; end
    else if ((ph == 1 && tr) || ph == 2) begin
      if (ph == 1) begin ph = 2; nv = 0; dl = dc; cnt = 0; end
      if (v) begin
        if (!DEC || nv % (dl + 1) == 0) begin
          e_we = 1; e_addr = cnt; e_din = d & 16'hFFFF; cnt++;
          if (cnt == LEN) ph = 3;
        end
        nv++;
      end
    end
    @(posedge fpga_clk);
    #1;
    check("we", 32'(bram_we), 32'(e_we));
    if (e_we) begin
      check("addr", 32'(bram_addr), e_addr);
      check("data", 32'(bram_din), e_din);
    end
    check("armed", 32'(armed), 32'(ph == 1));
    check("busy", 32'(busy), 32'(ph == 2));
    check("done", 32'(done), 32'(ph == 3));
    check("wr_count", 32'(wr_count), cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #12;
    check_zero();
    @(negedge fpga_clk);
    rst_n = 1'b1;
    mreset();
    idle(2);
    // trigger before arm is ignored
    cyc(0, 0, 1, 1, 16'h55, 0);
    // full burst with valid held, arm during capture ignored
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 20; i++) cyc(i == 6, 0, i == 0, 1, 16'h100 + i, 0);
    idle(2);
    // arm and abort together from DONE -> IDLE
    cyc(1, 1, 0, 0, 0, 0);
    idle(1);
    // valid toggling every other cycle
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, i == 0, i % 2 == 0, 16'h200 + i, 0);
    // abort when five samples have been written
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, cnt == 5 && ph == 2, i == 0, 1, 16'h300 + i, 0);
    idle(2);
    // decimation by 4: data 0,4,8,... when enabled
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) cyc(0, 0, i == 0, 1, i, 3);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    // asynchronous reset mid-capture
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, i == 0, 1, 16'h400 + i, 0);
    @(negedge fpga_clk);
    arm = 0; abort = 0; trigger = 0; din_valid = 0;
    #2 rst_n = 1'b0;
    #1 check_zero();
    mreset();
    @(negedge fpga_clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, i == 0, 1, 16'h500 + i, 0);
    idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
